// File: rtl/hs_ram_if.sv
// Handshake bundle for hs_ram: independent read/write channels with
// ready lines plus a shared address-exception flag.
interface hs_ram_if;
  logic [31:0] r_addr;
  logic [31:0] w_addr;
  logic [31:0] r_line;
  logic [31:0] w_line;
  logic        read;
  logic        write;
  logic        rrdy;
  logic        wrdy;
  logic        exc;

  modport master (
    output r_addr, w_addr, w_line, read, write,
    input  r_line, rrdy, wrdy, exc
  );

  modport slave (
    input  r_addr, w_addr, w_line, read, write,
    output r_line, rrdy, wrdy, exc
  );
endinterface

// File: rtl/hs_ram.sv
// Word-addressed 32-bit RAM with independent, fixed-latency read and write
// channels, each a two-state IDLE/BUSY handshake, and a shared range-error flag.
module hs_ram #(
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned LATENCY = 2
) (
  input logic   clk,
  input logic   rst,
  hs_ram_if.slave bus
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [31:0]   DEPTH_W  = 32'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  logic [31:0]   mem_r [DEPTH];

  state_t        rd_state_r;
  state_t        wr_state_r;
  logic [CW-1:0] rd_cnt_r;
  logic [CW-1:0] wr_cnt_r;
  logic          rd_err_r;
  logic          wr_err_r;
  logic [AW-1:0] rd_idx_r;
  logic [AW-1:0] wr_idx_r;
  logic [31:0]   wr_data_r;
  logic [31:0]   r_line_r;
  logic          rrdy_r;
  logic          wrdy_r;
  logic          exc_r;

  logic          rd_acc_s;
  logic          wr_acc_s;
  logic          rd_oor_s;
  logic          wr_oor_s;
  logic          wr_done_s;

  // Acceptance, range check and write-commit strobes
  always_comb begin
    rd_acc_s  = 1'b0;
    wr_acc_s  = 1'b0;
    rd_oor_s  = 1'b0;
    wr_oor_s  = 1'b0;
    wr_done_s = 1'b0;
    rd_acc_s  = (rd_state_r == IDLE) && bus.read;
    wr_acc_s  = (wr_state_r == IDLE) && bus.write;
    rd_oor_s  = (bus.r_addr >= DEPTH_W);
    wr_oor_s  = (bus.w_addr >= DEPTH_W);
    wr_done_s = (wr_state_r == BUSY) && (wr_cnt_r == CNT_ZERO) && !wr_err_r;
  end

  // Read channel FSM; an out-of-range access spends one cycle BUSY and skips the load
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_r <= IDLE;
      rd_cnt_r   <= CNT_ZERO;
      rd_err_r   <= 1'b0;
      rd_idx_r   <= '0;
      rrdy_r     <= 1'b1;
      r_line_r   <= 32'h0000_0000;
    end else begin
      case (rd_state_r)
        IDLE: begin
          if (bus.read) begin
            rd_state_r <= BUSY;
            rrdy_r     <= 1'b0;
            rd_idx_r   <= bus.r_addr[AW-1:0];
            rd_err_r   <= rd_oor_s;
            rd_cnt_r   <= rd_oor_s ? CNT_ZERO : CNT_LOAD;
          end
        end
        BUSY: begin
          if (rd_cnt_r == CNT_ZERO) begin
            rd_state_r <= IDLE;
            rrdy_r     <= 1'b1;
            if (!rd_err_r) begin
              r_line_r <= mem_r[rd_idx_r];
            end
          end else begin
            rd_cnt_r <= rd_cnt_r - CNT_ONE;
          end
        end
        default: begin
          rd_state_r <= IDLE;
          rrdy_r     <= 1'b1;
        end
      endcase
    end
  end

  // Write channel FSM; data is captured at acceptance so inputs may move afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_r <= IDLE;
      wr_cnt_r   <= CNT_ZERO;
      wr_err_r   <= 1'b0;
      wr_idx_r   <= '0;
      wr_data_r  <= 32'h0000_0000;
      wrdy_r     <= 1'b1;
    end else begin
      case (wr_state_r)
        IDLE: begin
          if (bus.write) begin
            wr_state_r <= BUSY;
            wrdy_r     <= 1'b0;
            wr_idx_r   <= bus.w_addr[AW-1:0];
            wr_data_r  <= bus.w_line;
            wr_err_r   <= wr_oor_s;
            wr_cnt_r   <= wr_oor_s ? CNT_ZERO : CNT_LOAD;
          end
        end
        BUSY: begin
          if (wr_cnt_r == CNT_ZERO) begin
            wr_state_r <= IDLE;
            wrdy_r     <= 1'b1;
          end else begin
            wr_cnt_r <= wr_cnt_r - CNT_ONE;
          end
        end
        default: begin
          wr_state_r <= IDLE;
          wrdy_r     <= 1'b1;
        end
      endcase
    end
  end

  // Storage array: not reset; a reset on the commit edge aborts the write
  always_ff @(posedge clk) begin
    if (!rst && wr_done_s) begin
      mem_r[wr_idx_r] <= wr_data_r;
    end
  end

  // Sticky exception, recomputed from whichever channels are accepted this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_r <= 1'b0;
    end else if (rd_acc_s || wr_acc_s) begin
      exc_r <= (rd_acc_s && rd_oor_s) || (wr_acc_s && wr_oor_s);
    end
  end

  assign bus.r_line = r_line_r;
  assign bus.rrdy   = rrdy_r;
  assign bus.wrdy   = wrdy_r;
  assign bus.exc    = exc_r;

endmodule

// File: tb/tb_hs_ram.sv
// Self-checking bench for hs_ram: directed scenarios plus randomized traffic
// compared against an associative-array memory model.
module tb_hs_ram;

  localparam int unsigned LAT     = 2;
  localparam logic [31:0] DEPTH_W = 32'd2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] exp_rline = 32'h0;
  bit          rl_known  = 1'b0;

  hs_ram_if bus ();

  hs_ram #(.DEPTH(2048), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on either or both channels, checked against the model
  task automatic op(input bit dr, input bit dw, input logic [31:0] ra,
                    input logic [31:0] wa, input logic [31:0] wd, input string tag);
    logic exp_exc;
    int   rlow;
    int   wlow;
    int   n;
    int   exp_rlow;
    int   exp_wlow;
    exp_exc  = (dr && ra >= DEPTH_W) || (dw && wa >= DEPTH_W);
    exp_rlow = dr ? ((ra >= DEPTH_W) ? 1 : LAT) : 0;
    exp_wlow = dw ? ((wa >= DEPTH_W) ? 1 : LAT) : 0;
    @(negedge clk);
    bus.read = dr; bus.write = dw;
    bus.r_addr = ra; bus.w_addr = wa; bus.w_line = wd;
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0;
    bus.r_addr = $urandom; bus.w_addr = $urandom; bus.w_line = $urandom;
    check({tag, "_exc"}, {31'd0, bus.exc}, {31'd0, exp_exc});
    rlow = (bus.rrdy === 1'b0) ? 1 : 0;
    wlow = (bus.wrdy === 1'b0) ? 1 : 0;
    n = 0;
    while ((bus.rrdy !== 1'b1 || bus.wrdy !== 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.rrdy !== 1'b1) rlow++;
      if (bus.wrdy !== 1'b1) wlow++;
    end
    check({tag, "_timeout"}, {31'd0, (n < 20)}, 32'd1);
    check({tag, "_rlow"}, 32'(rlow), 32'(exp_rlow));
    check({tag, "_wlow"}, 32'(wlow), 32'(exp_wlow));
    // read-before-write: the read sees the model before this write lands
    if (dr && ra < DEPTH_W) begin
      if (mem_m.exists(ra)) begin
        exp_rline = mem_m[ra];
        rl_known  = 1'b1;
      end else begin
        rl_known  = 1'b0;
      end
    end
    if (rl_known) check({tag, "_rline"}, bus.r_line, exp_rline);
    if (dw && wa < DEPTH_W) mem_m[wa] = wd;
  endtask

  task automatic wait_both(input logic lvl, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.rrdy === lvl && bus.wrdy === lvl) && n < 20);
    check(tag, {31'd0, (bus.rrdy === lvl && bus.wrdy === lvl)}, 32'd1);
  endtask

  initial begin
    bus.read = 1'b0; bus.write = 1'b0;
    bus.r_addr = 32'h0; bus.w_addr = 32'h0; bus.w_line = 32'h0;

    // reset held for two edges
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_rrdy", {31'd0, bus.rrdy}, 32'd1);
    check("rst_wrdy", {31'd0, bus.wrdy}, 32'd1);
    check("rst_exc", {31'd0, bus.exc}, 32'd0);
    check("rst_rline", bus.r_line, 32'h0);
    rst = 1'b0;
    exp_rline = 32'h0; rl_known = 1'b1;

    op(1'b0, 1'b1, 32'h0, 32'd5, 32'hA5A5_0001, "wr5");
    op(1'b1, 1'b0, 32'd5, 32'h0, 32'h0, "rd5");
    check("rd5_value", bus.r_line, 32'hA5A5_0001);

    // streaming with both requests held high
    @(negedge clk);
    bus.read = 1'b1; bus.write = 1'b1;
    bus.r_addr = 32'd0; bus.w_addr = 32'd1; bus.w_line = 32'd0;
    for (int i = 0; i < 2048; i++) begin
      wait_both(1'b0, "stream_acc");
      check("stream_exc", {31'd0, bus.exc}, {31'd0, (i == 2047)});
      if (i < 2047) begin
        bus.r_addr = 32'(i + 1);
        bus.w_addr = 32'(i + 2);
        bus.w_line = 32'(i + 1) << 1;
      end else begin
        bus.read = 1'b0; bus.write = 1'b0;
      end
      wait_both(1'b1, "stream_done");
      if (i >= 1) check("stream_rline", bus.r_line, 32'(2 * (i - 1)));
      if (i + 1 < 2048) mem_m[32'(i + 1)] = 32'(i) << 1;
    end
    exp_rline = 32'(2 * 2046); rl_known = 1'b1;
    check("stream_exc_sticky", {31'd0, bus.exc}, 32'd1);

    op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, "rd_oor");
    op(1'b1, 1'b0, 32'd100, 32'h0, 32'h0, "rd_clr");
    check("rd_clr_value", bus.r_line, 32'd198);

    op(1'b0, 1'b1, 32'h0, 32'd7, 32'h0000_0055, "wr7");
    op(1'b1, 1'b1, 32'd7, 32'd7, 32'h0000_1234, "coll7");
    check("coll7_old", bus.r_line, 32'h0000_0055);
    op(1'b1, 1'b0, 32'd7, 32'h0, 32'h0, "rd7");
    check("rd7_new", bus.r_line, 32'h0000_1234);

    // reset one cycle after acceptance aborts the write and clears exc
    op(1'b0, 1'b1, 32'h0, 32'd9, 32'hCAFE_0009, "wr9");
    @(negedge clk);
    bus.write = 1'b1; bus.w_addr = 32'd9; bus.w_line = 32'hDEAD_BEEF;
    bus.read = 1'b1; bus.r_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.write = 1'b0; bus.read = 1'b0;
    check("mid_wrdy_busy", {31'd0, bus.wrdy}, 32'd0);
    check("mid_exc_set", {31'd0, bus.exc}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_wrdy", {31'd0, bus.wrdy}, 32'd1);
    check("mid_rrdy", {31'd0, bus.rrdy}, 32'd1);
    check("mid_exc", {31'd0, bus.exc}, 32'd0);
    check("mid_rline", bus.r_line, 32'h0);
    exp_rline = 32'h0; rl_known = 1'b1;
    op(1'b1, 1'b0, 32'd9, 32'h0, 32'h0, "rd9");
    check("rd9_kept", bus.r_line, 32'hCAFE_0009);

    // randomized traffic over a small window plus the top word and out-of-range
    for (int k = 0; k < 80; k++) begin
      int unsigned sel;
      logic [31:0] ra;
      logic [31:0] wa;
      sel = $urandom_range(1, 3);
      ra  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_0800)
          : (($urandom_range(0, 9) == 0) ? 32'd2047 : 32'($urandom_range(0, 15)));
      wa  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_0800)
          : (($urandom_range(0, 9) == 0) ? 32'd2047 : 32'($urandom_range(0, 15)));
      op(sel[0], sel[1], ra, wa, $urandom, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_ram.md
Name: hs_ram

Overview:
- Word-addressed 32-bit data RAM with independent read and write channels.
- Each channel has its own ready/busy handshake and a multi-cycle access latency.
- A shared exception flag reports out-of-range addresses.
- Used as the CPU's handshaked data/program memory; the environment polls the ready lines to detect completion.

Parameters:
- DEPTH, 2048: number of 32-bit words; valid addresses are 0..DEPTH-1.
- LATENCY, 2: clock cycles from acceptance of an in-range access to completion; must be at least 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- r_addr  input  32  read word address.
- w_addr  input  32  write word address.
- r_line  output  32  read data, registered.
- w_line  input  32  write data.
- read  input  1  read request, level-sensitive.
- write  input  1  write request, level-sensitive.
- wrdy  output  1  write channel ready; 1 = idle or done, 0 = busy.
- rrdy  output  1  read channel ready; 1 = idle or done, 0 = busy.
- exc  output  1  address exception flag.

Behaviour:
- Reset (rst=1 at a rising edge): rrdy=1, wrdy=1, exc=0, r_line=0, latency counters cleared, pending operations aborted. Memory contents are not cleared; after reset they are unspecified. Reset has priority over everything, including mid-operation.
- Each channel is a 2-state FSM: IDLE (ready=1) and BUSY (ready=0). The read and write channels run fully independently and concurrently.
- Acceptance: at a rising edge where the channel is IDLE and its request (read/write) is 1:
  - The address is captured; for writes, w_line is also captured.
  - ready goes to 0 at that same edge.
  - Inputs may change freely after acceptance.
- In-range access (address < DEPTH):
  - The channel stays BUSY for LATENCY cycles.
  - At the LATENCY-th edge after acceptance, the read channel loads r_line with mem[addr] and the write channel performs mem[addr] <= data.
  - ready returns to 1 at that same edge.
- Out-of-range access (address >= DEPTH, full 32-bit compare):
  - exc goes to 1 at the acceptance edge, together with ready falling.
  - No memory update; r_line is unchanged.
  - The channel returns to IDLE (ready=1) at the next edge.
- exc behaviour:
  - exc is sticky until the next acceptance on either channel.
  - At each acceptance, exc is recomputed as the OR of the range errors of the channels accepted at that edge.
  - If only one channel is accepted, its error flag alone sets exc.
- While a channel is BUSY its request input and address are ignored; there is no queueing.
- A request held high continuously is re-accepted at the first edge the channel is IDLE. Completing at edge N and being re-accepted at edge N+1 therefore gives ready=1 for exactly one cycle.
- Read/write collision: a read completing at the same edge as a write to the same address returns the old data (read-before-write). A write completing earlier is visible to any read completing at a later edge.
- Addresses are word indices: no byte lanes, no alignment checks, no wrap-around.

Test Plan:
- Reset: assert rst for 2 cycles -> rrdy=1, wrdy=1, exc=0, r_line=0.
- Single write then read (DEPTH=2048, LATENCY=2):
  - write w_addr=5, w_line=0xA5A5_0001 -> wrdy low for exactly 2 cycles, exc=0.
  - then read r_addr=5 -> rrdy low 2 cycles, then r_line=0xA5A5_0001.
- Streaming loop, i=0..2047, read and write held high, each iteration waiting for both ready lines low then both high:
  - Each iteration writes (i<<1) to address i+1 and reads address i.
  - The read of address i returns 2*(i-1) for i>=1.
  - At i=2047, w_addr=2048 -> exc=1 on the edge the ready lines drop; memory unchanged.
- Out-of-range read: r_addr=0xFFFF_FFFF -> rrdy low for 1 cycle, exc=1, r_line keeps its prior value. A subsequent valid read clears exc at its acceptance edge.
- Same-address collision: write 0x1234 and read at address 7 accepted at the same edge, where address 7 holds 0x55 -> r_line=0x55; a later read of address 7 returns 0x1234.
- Reset mid-operation: assert rst one cycle after acceptance -> ready=1 on the next edge, no memory write, exc=0.
